// File: rtl/calc_pkg.sv
// Shared calculator definitions: default word width and operand-stack FSM encoding.
package calc_pkg;

  localparam int WORD_W = 32;

  typedef enum logic {
    ST_VALID  = 1'b0,
    ST_REFILL = 1'b1
  } stack_state_e;

endpackage

// File: rtl/calc_stack_ram.sv
// Single-port synchronous-read RAM holding the lower stack entries.
// One-cycle read latency; contents are not reset.
module calc_stack_ram #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];

  // Write on we, and read the same address every cycle (read-before-write).
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/calc_stack.sv
// LIFO operand stack. The top entry lives in a register; lower entries sit in
// calc_stack_ram. After a pop the new top is fetched from RAM, so out_vld drops
// for the one cycle the read is in flight.
// Optional feature: define CALC_STACK_HWM_EN to add the max_size high-water-mark output.
//
//   state     | meaning
//   ST_VALID  | top register holds entry size-1 (or 0 when empty)
//   ST_REFILL | RAM read data for the new top arrives this cycle
module calc_stack
  import calc_pkg::*;
#(
  parameter int WORD_W = calc_pkg::WORD_W,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] in_num,
  output logic [WORD_W-1:0] top,
  output logic [ADDR_W:0]   size,
  output logic              error,
  output logic              out_vld
`ifdef CALC_STACK_HWM_EN
  ,output logic [ADDR_W:0]  max_size
`endif
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] TWO   = ONE + ONE;

  stack_state_e      state_q, state_d;
  logic [ADDR_W:0]   size_q, size_d;
  logic [WORD_W-1:0] top_q, top_d;
  logic              err_q, err_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_wdata;
  logic [WORD_W-1:0] ram_rdata;

  logic              full, empty;
  logic              do_push, do_pop, do_replace;
  logic [ADDR_W:0]   size_m1, size_m2;

  assign full    = (size_q == DEPTH);
  assign empty   = (size_q == '0);
  assign size_m1 = size_q - ONE;
  assign size_m2 = size_q - TWO;

  // An overflowing or underflowing strobe is dropped as a whole, even when paired.
  assign do_replace = push &&  pop && !full && !empty;
  assign do_push    = push && !pop && !full;
  assign do_pop     = pop  && !push && !empty;

  calc_stack_ram #(
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Next-state decode for the FSM, size, top register, error flag and RAM port.
  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    top_d     = top_q;
    err_d     = err_q | (push && full) | (pop && empty);
    ram_we    = 1'b0;
    ram_addr  = size_m1[ADDR_W-1:0];
    ram_wdata = top_q;

    if (do_replace) begin
      top_d   = in_num;
      state_d = ST_VALID;
    end else if (do_push) begin
      // During a refill the register is stale; the entry being spilled is the
      // word coming back from RAM, so forward it.
      ram_we    = (state_q == ST_REFILL) || !empty;
      ram_wdata = (state_q == ST_REFILL) ? ram_rdata : top_q;
      top_d     = in_num;
      size_d    = size_q + ONE;
      state_d   = ST_VALID;
    end else if (do_pop) begin
      size_d = size_m1;
      if (size_q == ONE) begin
        top_d   = '0;
        state_d = ST_VALID;
      end else begin
        ram_addr = size_m2[ADDR_W-1:0];
        state_d  = ST_REFILL;
      end
    end else if (state_q == ST_REFILL) begin
      top_d   = ram_rdata;
      state_d = ST_VALID;
    end
  end

  // State registers; reset abandons any refill in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_VALID;
      size_q  <= '0;
      top_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      top_q   <= top_d;
      err_q   <= err_d;
    end
  end

`ifdef CALC_STACK_HWM_EN
  logic [ADDR_W:0] max_q;

  // High-water mark follows size on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            max_q <= '0;
    else if (size_d > max_q) max_q <= size_d;
  end

  assign max_size = max_q;
`endif

  assign top     = top_q;
  assign size    = size_q;
  assign error   = err_q;
  assign out_vld = (state_q == ST_VALID);

endmodule

// File: tb/tb_calc_stack.sv
// Bench for calc_stack: directed scenarios then random strobes, checked against
// a queue-based model of the stack contents.
module tb_calc_stack;

  localparam int WW    = 32;
  localparam int AW    = 2;
  localparam int DEPTH = 2**AW;

  logic          clk;
  logic          reset_n;
  logic          push;
  logic          pop;
  logic [WW-1:0] in_num;
  logic [WW-1:0] top;
  logic [AW:0]   size;
  logic          error;
  logic          out_vld;
`ifdef CALC_STACK_HWM_EN
  logic [AW:0]   max_size;
`endif

  calc_stack #(
    .WORD_W (WW),
    .ADDR_W (AW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop),
    .in_num   (in_num),
    .top      (top),
    .size     (size),
    .error    (error),
    .out_vld  (out_vld)
`ifdef CALC_STACK_HWM_EN
    ,.max_size (max_size)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned m_q[$];
  bit          m_pend;
  bit          m_err;
  int          m_max;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".size"}, 64'(size), 64'(m_q.size()));
    chk({tag, ".out_vld"}, 64'(out_vld), 64'(!m_pend));
    chk({tag, ".error"}, 64'(error), 64'(m_err));
    if (!m_pend)
      chk({tag, ".top"}, 64'(top), (m_q.size() > 0) ? 64'(m_q[m_q.size()-1]) : 64'd0);
`ifdef CALC_STACK_HWM_EN
    chk({tag, ".max_size"}, 64'(max_size), 64'(m_max));
`endif
  endtask

  // Called at a negedge: asserts reset, checks the async effect, releases at next negedge.
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    push = 1'b0; pop = 1'b0; in_num = '0;
    m_q.delete();
    m_pend = 0; m_err = 0; m_max = 0;
    #1;
    check_all(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Called at a negedge: applies one strobe cycle and updates the model.
  task automatic step(input bit p, input bit o, input logic [WW-1:0] n);
    push = p; pop = o; in_num = n;
    if (p && o) begin
      if (m_q.size() == 0 || m_q.size() == DEPTH) m_err = 1;
      else begin m_q[m_q.size()-1] = n; m_pend = 0; end
    end else if (p) begin
      if (m_q.size() == DEPTH) m_err = 1;
      else begin m_q.push_back(n); m_pend = 0; end
    end else if (o) begin
      if (m_q.size() == 0) m_err = 1;
      else begin void'(m_q.pop_back()); m_pend = (m_q.size() > 0); end
    end else begin
      m_pend = 0;
    end
    if (m_q.size() > m_max) m_max = m_q.size();
    @(posedge clk);
    @(negedge clk);
    push = 1'b0; pop = 1'b0;
  endtask

  initial begin
    int r;
    checks = 0; errors = 0;
    push = 1'b0; pop = 1'b0; in_num = '0; reset_n = 1'b1;
    @(negedge clk);
    do_reset("reset");

    // Pushes with idle gaps, then a pop and its refill.
    step(1, 0, 5);  check_all("t1.p5");
    step(0, 0, 0);  check_all("t1.idle");
    step(1, 0, 7);  check_all("t1.p7");
    step(0, 0, 0);  check_all("t1.idle");
    step(1, 0, 9);  check_all("t1.p9");
    step(0, 1, 0);  check_all("t2.pop");
    step(0, 0, 0);  check_all("t2.refill");

    // Fill to DEPTH, then overflow.
    step(1, 0, 1);     check_all("t3.p1");
    step(1, 0, 2);     check_all("t3.p2");
    step(1, 0, 'hAA);  check_all("t3.ovf");
    step(1, 1, 'hBB);  check_all("t3.ovf_rep");

    // Underflow on empty, then a push keeps error set.
    do_reset("t4.reset");
    step(0, 1, 0);  check_all("t4.unf");
    step(1, 1, 5);  check_all("t4.unf_rep");
    step(1, 0, 3);  check_all("t4.p3");

    // Replace.
    do_reset("t5.reset");
    step(1, 0, 4);        check_all("t5.p4");
    step(1, 0, 6);        check_all("t5.p6");
    step(1, 1, 'h0604);   check_all("t5.rep");

    // Push during refill, then pop back to the forwarded entry.
    do_reset("t6.reset");
    step(1, 0, 1);  step(1, 0, 2);  step(1, 0, 3);  check_all("t6.fill");
    step(0, 1, 0);  check_all("t6.pop");
    step(1, 0, 8);  check_all("t6.p8_refill");
    step(0, 1, 0);  check_all("t6.pop2");
    step(0, 0, 0);  check_all("t6.top2");

    // Pop in refill, then replace in refill.
    step(1, 0, 11); check_all("t6b.p11");
    step(0, 1, 0);  step(0, 1, 0);  check_all("t6b.pop_pop");
    step(1, 1, 44); check_all("t6b.rep_refill");

    // Reset while a refill is in flight.
    step(1, 0, 21); step(0, 1, 0);  check_all("t7.pop");
    do_reset("t7.reset_refill");

    // Random strobes against the model.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       step(1, 0, $urandom);
      else if (r < 8)  step(0, 1, 0);
      else if (r == 8) step(1, 1, $urandom);
      else             step(0, 0, 0);
      check_all("rand");
      if (i == 200) do_reset("rand.reset");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
